// File: rtl/ser_deframer_pkg.sv
// ---------------------------------------------------------------------------
// audionet_pkg
// Shared definitions for the AudioNet receive deframer slice: default link
// geometry, the sync FSM state type and a width helper for counters and
// pointers.
// ---------------------------------------------------------------------------
package audionet_pkg;

  localparam int AN_WORD_W     = 16;
  localparam int AN_FRAME_BITS = 256;
  localparam int AN_FIFO_DEPTH = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } sync_state_t;

  // Number of bits needed to index 0..n-1 (never less than one bit).
  function automatic int anCntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_deframer_if.sv
// ---------------------------------------------------------------------------
// ser_deframer_if
// Word delivery channel between the deframer and the downstream sample logic.
//   word_data  : head word of the deframer FIFO
//   word_first : head word is word 0 of its frame
//   word_valid : FIFO holds at least one word
//   word_ready : consumer takes the head word this cycle
// master = deframer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface ser_deframer_if import audionet_pkg::*; #(
  parameter int WORD_W = AN_WORD_W
) ();

  logic [WORD_W-1:0] word_data;
  logic              word_first;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_data,
    output word_first,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_first,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/ser_deframer_fifo.sv
// ---------------------------------------------------------------------------
// an_word_fifo
// Show-ahead FIFO for assembled words (data plus first-of-frame flag).
//   sclk, rstn   : clock, asynchronous active-low reset
//   i_push       : write i_pushData (ignored when full unless a pop happens)
//   i_pop        : consume the head entry (ignored when empty)
//   o_headData   : head entry, taken straight from the storage registers
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
// DEPTH must be a power of two so the pointers wrap by overflowing.
// ---------------------------------------------------------------------------
module an_word_fifo import audionet_pkg::*; #(
  parameter int DATA_W = AN_WORD_W + 1,
  parameter int DEPTH  = AN_FIFO_DEPTH
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_pushData,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_headData,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = anCntWidth(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic              w_pushOk;
  logic              w_popOk;

  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_headData = r_mem[r_rdPtr];

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push
  // when it is also being popped. Popping an empty FIFO does nothing.
  assign w_popOk  = i_pop && !o_empty;
  assign w_pushOk = i_push && (!o_full || w_popOk);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_pushOk, w_popOk})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ser_deframer.sv
// ---------------------------------------------------------------------------
// ser_deframer
// Receive-side deframer for the AudioNet serial link. Locks to the frame sync,
// assembles MSB-first words and hands them out through a small FIFO.
//   sclk, rstn : bit clock, asynchronous active-low reset
//   enable     : sample qualifier for sdata/sfs
//   sdata, sfs : serial bit and frame sync (sync marks bit 0 of a frame)
//   wordBus    : word_data/word_first/word_valid/word_ready channel
//   locked     : frame alignment established
//   sync_err   : one-cycle pulse on a missing or early sync
//   overflow   : sticky, a word was dropped on a full FIFO; ovf_clr clears it
// WORD_W must be at least 2 and divide FRAME_BITS.
// ---------------------------------------------------------------------------
module ser_deframer import audionet_pkg::*; #(
  parameter int WORD_W     = AN_WORD_W,
  parameter int FRAME_BITS = AN_FRAME_BITS,
  parameter int FIFO_DEPTH = AN_FIFO_DEPTH
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic                  sdata,
  input  logic                  sfs,
  ser_deframer_if.master        wordBus,
  output logic                  locked,
  output logic                  sync_err,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam int BCNT_W = anCntWidth(FRAME_BITS);

  sync_state_t       r_state;
  sync_state_t       w_nextState;
  logic [BCNT_W-1:0] r_bitCnt;
  logic [WORD_W-2:0] r_shift;
  logic              r_syncErr;
  logic              r_overflow;

  logic              w_take;
  logic [BCNT_W-1:0] w_bitIdx;
  logic              w_syncErr;
  logic [WORD_W-1:0] w_word;
  logic              w_push;
  logic              w_pushFirst;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [WORD_W:0]   w_head;

  // Next state plus which frame position the current bit occupies. A sync
  // always forces position 0, which covers both the initial lock and the
  // early-sync realignment; a missing sync discards the bit.
  always_comb begin
    w_nextState = r_state;
    w_take      = 1'b0;
    w_bitIdx    = r_bitCnt;
    w_syncErr   = 1'b0;
    if (enable) begin
      case (r_state)
        HUNT: begin
          if (sfs) begin
            w_nextState = LOCKED;
            w_take      = 1'b1;
            w_bitIdx    = '0;
          end
        end
        LOCKED: begin
          if (sfs) begin
            w_take    = 1'b1;
            w_bitIdx  = '0;
            w_syncErr = (r_bitCnt != '0);
          end else if (r_bitCnt == '0) begin
            w_nextState = HUNT;
            w_syncErr   = 1'b1;
          end else begin
            w_take = 1'b1;
          end
        end
        default: w_nextState = HUNT;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The shift register keeps only the WORD_W-1 most recent bits; the
  // incoming bit completes the word combinationally so it is pushed on the
  // same edge it is sampled. Stale bits from a discarded partial word are
  // shifted out before the next word completes.
  assign w_word      = {r_shift, sdata};
  assign w_push      = w_take && ((int'(w_bitIdx) % WORD_W) == (WORD_W - 1));
  assign w_pushFirst = (int'(w_bitIdx) < WORD_W);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_syncErr <= 1'b0;
    end else begin
      r_syncErr <= w_syncErr;
      if (w_take) begin
        r_shift  <= w_word[WORD_W-2:0];
        r_bitCnt <= (w_bitIdx == BCNT_W'(FRAME_BITS - 1)) ? '0 : w_bitIdx + BCNT_W'(1);
      end
    end
  end

  // A drop is a push that the FIFO refuses: full and not popped this edge.
  assign w_drop = w_push && w_full && !(wordBus.word_ready && !w_empty);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  an_word_fifo #(
    .DATA_W (WORD_W + 1),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .sclk       (sclk),
    .rstn       (rstn),
    .i_push     (w_push),
    .i_pushData ({w_pushFirst, w_word}),
    .i_pop      (wordBus.word_ready),
    .o_headData (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign wordBus.word_valid = !w_empty;
  assign wordBus.word_first = w_head[WORD_W];
  assign wordBus.word_data  = w_head[WORD_W-1:0];

  assign locked   = (r_state == LOCKED);
  assign sync_err = r_syncErr;
  assign overflow = r_overflow;

endmodule
